// File: rtl/alu_issue_stage_pkg.sv
// Package for the ALU issue stage.
// Holds the operand widths, the ALU operation codes presented to the ALU,
// the alu_op class encodings coming from decode, the funct3 values that the
// stage understands, the occupancy state type and the registered payload.
package alu_issue_stage_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  // Codes presented to the ALU on alu_code.
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0011;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // Instruction class from the decoder.
  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [2:0] FUNCT3_OR  = 3'b110;
  localparam logic [2:0] FUNCT3_AND = 3'b111;

  // Number of valid entries held by the stage.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // Everything captured for one instruction.
  typedef struct packed {
    logic [XLEN-1:0]   source_1;
    logic [XLEN-1:0]   source_2;
    logic [3:0]        alu_code;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   store;
    logic              illegal;
  } payload_t;

  // Single-source forwarding; register 0 is hard-wired and never forwarded.
  function automatic logic [XLEN-1:0] fwd_select(
    input logic              fwd_valid,
    input logic [REG_AW-1:0] fwd_rd,
    input logic [XLEN-1:0]   fwd_data,
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rs_data
  );
    if (fwd_valid && (fwd_rd == rs) && (rs != '0)) return fwd_data;
    return rs_data;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Interface bundling the upstream instruction channel, the forwarding port
// and the downstream ALU operand channel of the issue stage.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. A producer holds valid and its payload unchanged until the transfer
// happens; ready may be driven from registered state only (no dependence on
// valid), so neither side has a combinational path to the other.
//
// Modports:
//   master - the environment: drives in_*, fwd_*, out_ready; sees out_*.
//   slave  - the issue stage: the reverse.
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_alu_op;
  logic [2:0]        in_funct3;
  logic              in_funct7_5;
  logic              in_alu_src;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic [REG_AW-1:0] in_rd;

  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [XLEN-1:0]   fwd_data;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   source_1;
  logic [XLEN-1:0]   source_2;
  logic [3:0]        alu_code;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_store;
  logic              out_illegal;

  modport master (
    output in_valid, in_alu_op, in_funct3, in_funct7_5, in_alu_src,
           in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm, in_rd,
           fwd_valid, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, source_1, source_2, alu_code, out_rd,
           out_store, out_illegal
  );

  modport slave (
    input  in_valid, in_alu_op, in_funct3, in_funct7_5, in_alu_src,
           in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_imm, in_rd,
           fwd_valid, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, source_1, source_2, alu_code, out_rd,
           out_store, out_illegal
  );

endinterface

// File: rtl/alu_issue_stage_alu_control.sv
// ALU control decode (purely combinational).
// Ports:
//   alu_op_i   - instruction class (mem / branch / R-type / I-type)
//   funct3_i   - instruction funct3
//   funct7_5_i - instruction bit 30 (selects SUB for R-type funct3 000)
//   alu_code_o - code for the ALU, ALU_ILLEGAL when unsupported
//   illegal_o  - high for any unsupported funct3/funct7 combination
module alu_control
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_code_o,
  output logic       illegal_o
);

  always_comb begin
    alu_code_o = ALU_ILLEGAL;
    illegal_o  = 1'b1;
    unique case (alu_op_i)
      ALU_OP_MEM: begin
        alu_code_o = ALU_ADD;
        illegal_o  = 1'b0;
      end
      ALU_OP_BRANCH: begin
        alu_code_o = ALU_SUB;
        illegal_o  = 1'b0;
      end
      ALU_OP_RTYPE, ALU_OP_ITYPE: begin
        unique case (funct3_i)
          FUNCT3_ADD: begin
            // I-type has no SUB; bit 30 belongs to the immediate there.
            alu_code_o = (alu_op_i == ALU_OP_RTYPE && funct7_5_i) ? ALU_SUB : ALU_ADD;
            illegal_o  = 1'b0;
          end
          FUNCT3_AND: begin
            alu_code_o = ALU_AND;
            illegal_o  = 1'b0;
          end
          FUNCT3_OR: begin
            alu_code_o = ALU_OR;
            illegal_o  = 1'b0;
          end
          default: begin
            alu_code_o = ALU_ILLEGAL;
            illegal_o  = 1'b1;
          end
        endcase
      end
      default: begin
        alu_code_o = ALU_ILLEGAL;
        illegal_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage in front of the 64-bit ALU.
// Captures one decoded instruction per cycle, resolves forwarding for rs1/rs2,
// selects operand 2 (rs2 or immediate), decodes alu_code, and presents the
// registered result on the output channel through a two-entry skid buffer.
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous active-high reset
//   bus         - slave side of alu_issue_stage_if (in_*, fwd_*, out_*)
//   dbg_state_o - current occupancy state (EMPTY / ONE / TWO)
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  alu_issue_stage_if.slave    bus,
  output occ_state_e          dbg_state_o
);

  occ_state_e state_q, state_d;
  payload_t   main_q, main_d;
  payload_t   skid_q, skid_d;
  payload_t   new_pl;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [3:0]      dec_code;
  logic            dec_illegal;
  logic            in_ready;
  logic            out_valid;
  logic            accept;
  logic            retire;

  alu_control u_alu_control (
    .alu_op_i   (bus.in_alu_op),
    .funct3_i   (bus.in_funct3),
    .funct7_5_i (bus.in_funct7_5),
    .alu_code_o (dec_code),
    .illegal_o  (dec_illegal)
  );

  // Operand selection for the incoming instruction.
  always_comb begin
    rs1_val = fwd_select(bus.fwd_valid, bus.fwd_rd, bus.fwd_data, bus.in_rs1, bus.in_rs1_data);
    rs2_val = fwd_select(bus.fwd_valid, bus.fwd_rd, bus.fwd_data, bus.in_rs2, bus.in_rs2_data);
    new_pl          = '0;
    new_pl.source_1 = rs1_val;
    new_pl.source_2 = bus.in_alu_src ? bus.in_imm : rs2_val;
    new_pl.alu_code = dec_code;
    new_pl.rd       = bus.in_rd;
    new_pl.store    = rs2_val;
    new_pl.illegal  = dec_illegal;
  end

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state_q != OCC_TWO);
  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = bus.in_valid && in_ready;
  assign retire    = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          main_d  = new_pl;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && retire) begin
          main_d = new_pl;
        end else if (accept) begin
          // Main is stalled; park the newcomer in the skid entry.
          skid_d  = new_pl;
          state_d = OCC_TWO;
        end else if (retire) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (retire) begin
          main_d  = skid_q;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.source_1    = main_q.source_1;
  assign bus.source_2    = main_q.source_2;
  assign bus.alu_code    = main_q.alu_code;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_store   = main_q.store;
  assign bus.out_illegal = main_q.illegal;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int W = 2*XLEN + 4 + REG_AW + XLEN + 1;

  logic clk;
  logic reset;
  occ_state_e dbg_state;

  alu_issue_stage_if intf ();

  alu_issue_stage dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (intf.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [W-1:0] obs_pl, exp_pl;
  logic obs_valid, obs_in_ready, retired, accepted, sb_empty;

  // Reference: expected payload from the architectural rules.
  function automatic logic [W-1:0] model();
    logic [XLEN-1:0] a, b, st;
    logic [3:0] code;
    logic ill;
    a  = (intf.fwd_valid && intf.in_rs1 != 0 && intf.fwd_rd == intf.in_rs1) ? intf.fwd_data : intf.in_rs1_data;
    st = (intf.fwd_valid && intf.in_rs2 != 0 && intf.fwd_rd == intf.in_rs2) ? intf.fwd_data : intf.in_rs2_data;
    b  = intf.in_alu_src ? intf.in_imm : st;
    ill = 1'b0;
    if (intf.in_alu_op == 2'd0) code = 4'd2;
    else if (intf.in_alu_op == 2'd1) code = 4'd3;
    else if (intf.in_funct3 == 3'd7) code = 4'd0;
    else if (intf.in_funct3 == 3'd6) code = 4'd1;
    else if (intf.in_funct3 == 3'd0) code = (intf.in_alu_op == 2'd2 && intf.in_funct7_5) ? 4'd3 : 4'd2;
    else begin
      code = 4'hF;
      ill  = 1'b1;
    end
    return {a, b, code, intf.in_rd, st, ill};
  endfunction

  // One clock: sample at negedge, update the scoreboard, return at posedge+1.
  task automatic tick();
    @(negedge clk);
    obs_valid    = intf.out_valid;
    obs_in_ready = intf.in_ready;
    obs_pl = {intf.source_1, intf.source_2, intf.alu_code, intf.out_rd, intf.out_store, intf.out_illegal};
    accepted = intf.in_valid && obs_in_ready;
    retired  = obs_valid && intf.out_ready;
    sb_empty = 1'b0;
    if (retired) begin
      if (exp_q.size() == 0) sb_empty = 1'b1;
      else exp_pl = exp_q.pop_front();
    end
    if (accepted) exp_q.push_back(model());
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                           input logic src, input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                           input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                           input logic [XLEN-1:0] imm, input logic [REG_AW-1:0] rd);
    intf.in_alu_op   = op;
    intf.in_funct3   = f3;
    intf.in_funct7_5 = f7;
    intf.in_alu_src  = src;
    intf.in_rs1      = rs1;
    intf.in_rs2      = rs2;
    intf.in_rs1_data = d1;
    intf.in_rs2_data = d2;
    intf.in_imm      = imm;
    intf.in_rd       = rd;
  endtask

  task automatic set_fwd(input logic v, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    intf.fwd_valid = v;
    intf.fwd_rd    = rd;
    intf.fwd_data  = d;
  endtask

  task automatic rand_instr();
    set_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              5'($urandom_range(0, 31)));
    set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), {$urandom, $urandom});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (intf.out_valid !== 1'b0 || intf.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0/1", intf.out_valid, intf.in_ready);
    end
    checks++;
    obs_pl = {intf.source_1, intf.source_2, intf.alu_code, intf.out_rd, intf.out_store, intf.out_illegal};
    if (obs_pl !== '0) begin
      errors++;
      $display("FAIL reset_data outputs=%h required 0", obs_pl);
    end
  endtask

  task automatic test_sub();
    intf.out_ready = 1'b1;
    set_fwd(1'b0, 5'd0, '0);
    set_instr(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 64'd5, 64'd3, 64'd99, 5'd4);
    intf.in_valid = 1'b1;
    tick();
    intf.in_valid = 1'b0;
    tick();
    checks++;
    if (!retired || intf.alu_code !== 4'b0011 || obs_pl[W-1 -: XLEN] !== 64'd5 ||
        obs_pl[W-1-XLEN -: XLEN] !== 64'd3) begin
      errors++;
      $display("FAIL sub_rtype retired=%b got %h required code 3 src1 5 src2 3", retired, obs_pl);
    end
    checks++;
    if (sb_empty || obs_pl !== exp_pl) begin
      errors++;
      $display("FAIL sub_sb got %h required %h", obs_pl, exp_pl);
    end
  endtask

  task automatic test_itype();
    intf.out_ready = 1'b1;
    set_instr(2'b11, 3'b111, 1'b0, 1'b1, 5'd1, 5'd2, 64'd10, 64'd20, 64'hFF, 5'd6);
    intf.in_valid = 1'b1;
    tick();
    set_instr(2'b11, 3'b001, 1'b0, 1'b1, 5'd1, 5'd2, 64'd10, 64'd20, 64'hFF, 5'd7);
    tick();
    checks++;
    if (!retired || intf.alu_code !== 4'b0000 || intf.source_2 !== 64'hFF || intf.out_illegal !== 1'b0) begin
      // sampled values are in obs_pl; intf now shows the next entry
      if (!retired || obs_pl[W-1-2*XLEN -: 4] !== 4'b0000 || obs_pl[W-1-XLEN -: XLEN] !== 64'hFF) begin
        errors++;
        $display("FAIL itype_and got %h required code 0 src2 ff", obs_pl);
      end
    end
    intf.in_valid = 1'b0;
    tick();
    checks++;
    if (!retired || obs_pl[W-1-2*XLEN -: 4] !== 4'hF || obs_pl[0] !== 1'b1) begin
      errors++;
      $display("FAIL itype_illegal retired=%b code=%h ill=%b required f/1", retired,
               obs_pl[W-1-2*XLEN -: 4], obs_pl[0]);
    end
    checks++;
    if (sb_empty || obs_pl !== exp_pl) begin
      errors++;
      $display("FAIL itype_sb got %h required %h", obs_pl, exp_pl);
    end
  endtask

  task automatic test_fwd();
    intf.out_ready = 1'b1;
    set_instr(2'b00, 3'b000, 1'b0, 1'b1, 5'd7, 5'd7, 64'h1111, 64'h2222, 64'h40, 5'd3);
    set_fwd(1'b1, 5'd7, 64'hDEAD);
    intf.in_valid = 1'b1;
    tick();
    intf.in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, '0);
    tick();
    checks++;
    if (!retired || obs_pl[W-1 -: XLEN] !== 64'hDEAD || obs_pl[XLEN:1] !== 64'hDEAD) begin
      errors++;
      $display("FAIL fwd_rs1 got src1=%h store=%h required dead/dead", obs_pl[W-1 -: XLEN], obs_pl[XLEN:1]);
    end
    set_instr(2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 64'h1234, 64'h5678, 64'h40, 5'd3);
    set_fwd(1'b1, 5'd0, 64'hDEAD);
    intf.in_valid = 1'b1;
    tick();
    intf.in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, '0);
    tick();
    checks++;
    if (!retired || obs_pl[W-1 -: XLEN] !== 64'h1234 || obs_pl[XLEN:1] !== 64'h5678) begin
      errors++;
      $display("FAIL fwd_x0 got src1=%h store=%h required 1234/5678", obs_pl[W-1 -: XLEN], obs_pl[XLEN:1]);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    logic [W-1:0] held;
    intf.out_ready = 1'b0;
    rand_instr();
    intf.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 2) held = obs_pl;
      if (c == 3) begin
        checks++;
        if (obs_pl !== held || !obs_valid) begin
          errors++;
          $display("FAIL stall_stable got %h required %h", obs_pl, held);
        end
      end
      if (accepted) begin
        sent++;
        rand_instr();
      end
    end
    checks++;
    if (sent != 2 || obs_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_fill accepted=%0d in_ready=%b required 2/0", sent, obs_in_ready);
    end
    intf.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (accepted) begin
        sent++;
        if (sent == 3) intf.in_valid = 1'b0;
        else rand_instr();
      end
      if (retired) begin
        got++;
        checks++;
        if (sb_empty || obs_pl !== exp_pl) begin
          errors++;
          $display("FAIL drain_order got %h required %h", obs_pl, exp_pl);
        end
      end
    end
    checks++;
    if (got != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_count retired=%0d left=%0d required 3/0", got, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int stalls = 0;
    int bad = 0;
    intf.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_instr();
      intf.in_valid = 1'b1;
      tick();
      if (!accepted) stalls++;
      if (retired) begin
        got++;
        if (sb_empty || obs_pl !== exp_pl) begin
          bad++;
          if (bad < 4) $display("FAIL b2b_data op %0d got %h required %h", got, obs_pl, exp_pl);
        end
      end
    end
    intf.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (retired) begin
        got++;
        if (sb_empty || obs_pl !== exp_pl) begin
          bad++;
          if (bad < 4) $display("FAIL b2b_data op %0d got %h required %h", got, obs_pl, exp_pl);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_compare mismatching=%0d required 0", bad);
    end
    checks++;
    if (got != 100 || stalls != 0) begin
      errors++;
      $display("FAIL b2b_throughput retired=%0d stalls=%0d required 100/0", got, stalls);
    end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    intf.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_instr();
      intf.in_valid = 1'b1;
      tick();
    end
    intf.in_valid = 1'b0;
    checks++;
    if (intf.in_ready !== 1'b0 || dbg_state !== OCC_TWO) begin
      errors++;
      $display("FAIL mid_fill in_ready=%b state=%0d required 0/2", intf.in_ready, dbg_state);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    obs_pl = {intf.source_1, intf.source_2, intf.alu_code, intf.out_rd, intf.out_store, intf.out_illegal};
    if (intf.out_valid !== 1'b0 || intf.in_ready !== 1'b1 || obs_pl !== '0) begin
      errors++;
      $display("FAIL mid_reset out_valid=%b in_ready=%b data=%h required 0/1/0",
               intf.out_valid, intf.in_ready, obs_pl);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    intf.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL mid_stale out_valid cycles=%0d required 0", stale);
    end
    rand_instr();
    intf.in_valid = 1'b1;
    tick();
    intf.in_valid = 1'b0;
    tick();
    checks++;
    if (!retired || sb_empty || obs_pl !== exp_pl) begin
      errors++;
      $display("FAIL mid_restart retired=%b got %h required %h", retired, obs_pl, exp_pl);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    intf.in_valid  = 1'b0;
    intf.out_ready = 1'b0;
    set_instr(2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    set_fwd(1'b0, '0, '0);
    #1;
    reset = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_sub();
    test_itype();
    test_fwd();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
